// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and bus-level constants
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_t;

  localparam int         BITS_PER_BYTE   = 8;
  localparam logic [2:0] LAST_BIT        = 3'(BITS_PER_BYTE - 1);
  localparam logic       START_SDA_LEVEL = 1'b0;
  localparam logic       STOP_SDA_LEVEL  = 1'b1;
  localparam logic       SDA_ACK         = 1'b0;
  localparam logic       SDA_NACK        = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with SCL edge and START/STOP detection
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // Reset to the idle bus level so release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & (sda_q != sda_s) & (sda_s == START_SDA_LEVEL);
  assign stop_det  = scl_s & scl_q & (sda_q != sda_s) & (sda_s == STOP_SDA_LEVEL);

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing a small register file with auto-incrementing pointer
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h54,
  parameter int         NUM_REGS    = 8,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iSCL,
  input  logic          iSDA,
  output logic          oSDA_Oe,
  input  logic [PW-1:0] iHost_Addr,
  output logic [7:0]    oHost_Data,
  output logic          oWr_Valid,
  output logic [PW-1:0] oWr_Addr,
  output logic [7:0]    oWr_Data,
  output logic          oBusy
);

  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;
  i2c_state_t    state;
  logic [7:0]    regs [NUM_REGS];
  logic [PW-1:0] ptr;
  logic [7:0]    sr;
  logic [2:0]    cnt;
  logic          rw;
  logic [7:0]    nxt;
  logic [7:0]    rd_byte;

  i2c_bus_sync u_sync (
    .clk       (iClk),
    .rst       (iRst),
    .scl       (iSCL),
    .sda       (iSDA),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign nxt        = {sr[6:0], sda_s};
  assign rd_byte    = regs[ptr];
  assign oHost_Data = regs[iHost_Addr];

  // In the ACK states oSDA_Oe doubles as the phase: first fall drives ACK, second fall ends it.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= ST_IDLE;
      oSDA_Oe   <= 1'b0;
      oWr_Valid <= 1'b0;
      oWr_Addr  <= '0;
      oWr_Data  <= '0;
      oBusy     <= 1'b0;
      ptr       <= '0;
      sr        <= '0;
      cnt       <= '0;
      rw        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      oWr_Valid <= 1'b0;
      if (stop_det) begin
        state   <= ST_IDLE;
        oSDA_Oe <= 1'b0;
        oBusy   <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        oSDA_Oe <= 1'b0;
        cnt     <= '0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            sr  <= nxt;
            cnt <= cnt + 3'd1;
            if (cnt == LAST_BIT) begin
              if (nxt[7:1] == TARGET_ADDR) begin
                state <= ST_ADDR_ACK;
                rw    <= nxt[0];
                oBusy <= 1'b1;
              end else begin
                state <= ST_IDLE;
                oBusy <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            cnt <= '0;
            if (!oSDA_Oe) begin
              oSDA_Oe <= 1'b1;
            end else if (rw) begin
              state   <= ST_RDATA;
              oSDA_Oe <= ~rd_byte[7];
              sr      <= {rd_byte[6:0], 1'b0};
            end else begin
              state   <= ST_PTR;
              oSDA_Oe <= 1'b0;
            end
          end
          ST_PTR: if (scl_rise) begin
            sr  <= nxt;
            cnt <= cnt + 3'd1;
            if (cnt == LAST_BIT) begin
              ptr   <= nxt[PW-1:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            sr  <= nxt;
            cnt <= cnt + 3'd1;
            if (cnt == LAST_BIT) begin
              regs[ptr] <= nxt;
              oWr_Valid <= 1'b1;
              oWr_Addr  <= ptr;
              oWr_Data  <= nxt;
              ptr       <= ptr + PW'(1);
              state     <= ST_WDATA_ACK;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            cnt <= '0;
            if (!oSDA_Oe) begin
              oSDA_Oe <= 1'b1;
            end else begin
              oSDA_Oe <= 1'b0;
              state   <= ST_WDATA;
            end
          end
          ST_RDATA: if (scl_fall) begin
            if (cnt == LAST_BIT) begin
              oSDA_Oe <= 1'b0;
              ptr     <= ptr + PW'(1);
              cnt     <= '0;
              state   <= ST_RDATA_ACK;
            end else begin
              oSDA_Oe <= ~sr[7];
              sr      <= {sr[6:0], 1'b0};
              cnt     <= cnt + 3'd1;
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s == SDA_NACK) state <= ST_IDLE;
              else                   cnt   <= 3'd1;
            end else if (scl_fall && cnt == 3'd1) begin
              state   <= ST_RDATA;
              oSDA_Oe <= ~rd_byte[7];
              sr      <= {rd_byte[6:0], 1'b0};
              cnt     <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bus-level randomized bench for i2c_target_regs with a register-file model
module tb_i2c_target_regs;

  localparam logic [6:0] ADDR = 7'h54;
  localparam int         N    = 8;
  localparam int         PW   = 3;
  localparam int         Q    = 6;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          scl = 1'b1;
  logic          sda_drv = 1'b1;
  logic          iSDA;
  logic          oSDA_Oe;
  logic [PW-1:0] iHost_Addr = '0;
  logic [7:0]    oHost_Data;
  logic          oWr_Valid;
  logic [PW-1:0] oWr_Addr;
  logic [7:0]    oWr_Data;
  logic          oBusy;

  int            n_chk = 0;
  int            n_pass = 0;
  int            n_wr = 0;
  logic [7:0]    m_regs [N];
  int            m_ptr = 0;
  logic [PW+7:0] exp_wr [$];
  logic [7:0]    wr_q [$];
  logic [7:0]    rd_got [$];
  bit            quiet = 1'b0;

  assign iSDA = sda_drv & ~oSDA_Oe;
  always #5 iClk = ~iClk;

  i2c_target_regs #(.TARGET_ADDR(ADDR), .NUM_REGS(N)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iSCL       (scl),
    .iSDA       (iSDA),
    .oSDA_Oe    (oSDA_Oe),
    .iHost_Addr (iHost_Addr),
    .oHost_Data (oHost_Data),
    .oWr_Valid  (oWr_Valid),
    .oWr_Addr   (oWr_Addr),
    .oWr_Data   (oWr_Data),
    .oBusy      (oBusy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, plus write scoreboard and SDA discipline.
  initial begin
    logic          oe_prev;
    logic          scl_prev;
    logic [PW+7:0] e;
    oe_prev  = 1'b0;
    scl_prev = 1'b1;
    forever begin
      @(negedge iClk);
      if (oWr_Valid) begin
        n_wr++;
        check("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", oWr_Addr, e[PW+7:8]);
          check("wr_data", oWr_Data, e[7:0]);
          m_regs[e[PW+7:8]] = e[7:0];
        end
      end
      check("host_data", oHost_Data, m_regs[iHost_Addr]);
      if (!iRst) check("oe_rise_scl_high", oSDA_Oe & ~oe_prev & scl & scl_prev, 0);
      if (quiet) begin
        check("quiet_oe", oSDA_Oe, 0);
        check("quiet_busy", oBusy, 0);
      end
      oe_prev    = oSDA_Oe;
      scl_prev   = scl;
      iHost_Addr = PW'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic qwait();
    repeat (Q) @(posedge iClk);
    #1;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; qwait();
    scl = 1'b1;     qwait();
    sda_drv = 1'b0; qwait();
    scl = 1'b0;     qwait();
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; qwait();
    scl = 1'b1;     qwait();
    sda_drv = 1'b1; qwait();
    qwait();
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; qwait();
    scl = 1'b1;  qwait(); qwait();
    scl = 1'b0;  qwait();
  endtask

  task automatic recv_bit(output logic b);
    sda_drv = 1'b1; qwait();
    scl = 1'b1;     qwait();
    b = iSDA;       qwait();
    scl = 1'b0;     qwait();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic nack);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      v = {v[6:0], b};
    end
    send_bit(nack);
  endtask

  // wr_q holds the pointer byte followed by data bytes.
  task automatic wr_txn(input logic [6:0] a, input bit do_stop);
    logic ack;
    bit   hit;
    hit = (a == ADDR);
    bus_start();
    send_byte({a, 1'b0}, ack);
    check("addr_ack", ack, !hit);
    if (hit) check("busy_addressed", oBusy, 1);
    for (int i = 0; i < wr_q.size(); i++) begin
      if (hit && i > 0) begin
        exp_wr.push_back({PW'(m_ptr), wr_q[i]});
        m_ptr = (m_ptr + 1) % N;
      end
      send_byte(wr_q[i], ack);
      check("byte_ack", ack, !hit);
      if (hit && i == 0) m_ptr = wr_q[0] % N;
    end
    if (do_stop) begin
      bus_stop();
      check("busy_after_stop", oBusy, 0);
    end
  endtask

  task automatic rd_txn(input int n);
    logic       ack;
    logic       b;
    logic [7:0] v;
    bus_start();
    send_byte({ADDR, 1'b1}, ack);
    check("rd_addr_ack", ack, 0);
    rd_got.delete();
    for (int i = 0; i < n; i++) begin
      recv_byte(v, i == n - 1);
      check("rd_data", v, m_regs[m_ptr]);
      rd_got.push_back(v);
      m_ptr = (m_ptr + 1) % N;
    end
    recv_bit(b);
    check("sda_free_after_nack", b, 1);
    bus_stop();
    check("busy_after_stop", oBusy, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    exp_wr.delete();
  endtask

  initial begin
    int         w0;
    int         kind;
    int         nb;
    logic       ack;
    logic [6:0] a;
    model_reset();
    repeat (3) @(posedge iClk);
    #1;
    check("rst_oe", oSDA_Oe, 0);
    check("rst_busy", oBusy, 0);
    check("rst_wr_valid", oWr_Valid, 0);
    check("rst_wr_addr", oWr_Addr, 0);
    check("rst_wr_data", oWr_Data, 0);
    iRst = 1'b0;
    qwait();

    w0 = n_wr;
    wr_q = '{8'h01, 8'hAA};
    wr_txn(ADDR, 1);
    check("single_write_pulses", n_wr - w0, 1);
    check("single_write_reg1", m_regs[1], 8'hAA);

    wr_q = '{8'h06, 8'h11, 8'h22, 8'h33};
    wr_txn(ADDR, 1);
    check("wrap_reg6", m_regs[6], 8'h11);
    check("wrap_reg7", m_regs[7], 8'h22);
    check("wrap_reg0", m_regs[0], 8'h33);
    check("wrap_ptr", m_ptr, 1);
    rd_txn(1);
    check("wrap_read_reg1", rd_got[0], 8'hAA);

    wr_q = '{8'h02, 8'h5A, 8'hC3};
    wr_txn(ADDR, 1);
    wr_q = '{8'h02};
    wr_txn(ADDR, 0);
    rd_txn(2);
    check("restart_read0", rd_got[0], 8'h5A);
    check("restart_read1", rd_got[1], 8'hC3);

    w0 = n_wr;
    quiet = 1'b1;
    wr_q = '{8'h01, 8'hAA};
    wr_txn(7'h55, 1);
    quiet = 1'b0;
    check("mismatch_pulses", n_wr - w0, 0);

    w0 = n_wr;
    bus_start();
    send_byte({ADDR, 1'b0}, ack);
    send_byte(8'h04, ack);
    m_ptr = 4;
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    bus_stop();
    check("partial_pulses", n_wr - w0, 0);
    check("partial_busy", oBusy, 0);
    check("partial_oe", oSDA_Oe, 0);
    rd_txn(1);

    wr_q = '{8'h04, 8'h00};
    wr_txn(ADDR, 1);
    wr_q = '{8'h04};
    wr_txn(ADDR, 1);
    bus_start();
    send_byte({ADDR, 1'b1}, ack);
    for (int i = 0; i < 3; i++) recv_bit(ack);
    check("rdata_driving", oSDA_Oe, 1);
    iRst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_oe", oSDA_Oe, 0);
    scl = 1'b1;
    sda_drv = 1'b1;
    repeat (4) @(posedge iClk);
    #1;
    iRst = 1'b0;
    qwait();
    wr_q = '{8'h03, 8'h9C};
    wr_txn(ADDR, 1);
    check("post_rst_reg3", m_regs[3], 8'h9C);

    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      nb   = $urandom_range(1, 3);
      wr_q.delete();
      wr_q.push_back(8'($urandom));
      case (kind)
        0: begin
          for (int i = 0; i < nb; i++) wr_q.push_back(8'($urandom));
          wr_txn(ADDR, 1);
        end
        1: rd_txn(nb);
        2: begin
          wr_txn(ADDR, 0);
          rd_txn(nb);
        end
        default: begin
          a = 7'($urandom);
          if (a == ADDR) a = a ^ 7'h01;
          wr_q.push_back(8'($urandom));
          quiet = 1'b1;
          wr_txn(a, 1);
          quiet = 1'b0;
        end
      endcase
    end

    qwait();
    check("writes_all_seen", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
